// File: rtl/pick_arbiter.sv
// Round-robin arbiter granting one sensor channel per pixel packet to a shared picker.
// Validates the three header words and releases the grant on a bad header or dropped request.
module pick_arbiter #(
  parameter int pixelWidth = 16,
  parameter int numPixel   = 16,
  parameter int NUM_CH     = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_CH-1:0]              REQ,
  input  logic [NUM_CH*pixelWidth-1:0]   DIN_ARR,
  output logic [NUM_CH-1:0]              GNT,
  output logic                           rcvReady,
  output logic [pixelWidth-1:0]          DOUT,
  output logic [$clog2(NUM_CH)-1:0]      CH_ID,
  output logic                           PKT_DONE,
  output logic                           ABORT
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int PKT_WORDS = numPixel + 4;
  localparam int CNT_W     = $clog2(PKT_WORDS);

  localparam logic [pixelWidth-1:0] HDR_SYNC = pixelWidth'(16'hFFFF);
  localparam logic [pixelWidth-1:0] HDR_MARK = pixelWidth'(16'hAAAA);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CH_W-1:0]  ch_id_reg, ch_id_next;
  logic [CH_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] word_cnt_reg, word_cnt_next;

  logic [pixelWidth-1:0] din_ch [NUM_CH];
  logic                  pick_found;
  logic [CH_W-1:0]       pick_idx;
  logic [CH_W-1:0]       cand;
  logic                  hdr_bad;
  logic                  req_lost;
  logic                  pkt_last;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slice
      assign din_ch[gi] = DIN_ARR[gi*pixelWidth +: pixelWidth];
    end
  endgenerate

  // Search starts one past the last served channel so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr_reg) + i) % NUM_CH);
      if (!pick_found && REQ[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ch_id_next    = ch_id_reg;
    rr_ptr_next   = rr_ptr_reg;
    word_cnt_next = word_cnt_reg;
    hdr_bad       = 1'b0;
    req_lost      = 1'b0;
    pkt_last      = 1'b0;
    GNT           = '0;
    rcvReady      = 1'b0;
    DOUT          = '0;
    PKT_DONE      = 1'b0;
    ABORT         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = STREAM;
          ch_id_next    = pick_idx;
          word_cnt_next = '0;
        end
      end

      STREAM: begin
        GNT[ch_id_reg] = 1'b1;
        rcvReady       = 1'b1;
        DOUT           = din_ch[ch_id_reg];
        req_lost       = !REQ[ch_id_reg];
        pkt_last       = (word_cnt_reg == CNT_W'(PKT_WORDS - 1));

        if (word_cnt_reg == CNT_W'(0) || word_cnt_reg == CNT_W'(1))
          hdr_bad = (din_ch[ch_id_reg] != HDR_SYNC);
        else if (word_cnt_reg == CNT_W'(2))
          hdr_bad = (din_ch[ch_id_reg] != HDR_MARK);

        if (hdr_bad || req_lost) begin
          ABORT       = 1'b1;
          state_next  = GAP;
          rr_ptr_next = ch_id_reg;
        end else if (pkt_last) begin
          PKT_DONE    = 1'b1;
          state_next  = GAP;
          rr_ptr_next = ch_id_reg;
        end else begin
          word_cnt_next = word_cnt_reg + 1'b1;
        end
      end

      // One dead cycle lets the picker fall back to header search.
      GAP: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      ch_id_reg    <= '0;
      rr_ptr_reg   <= CH_W'(NUM_CH - 1);
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ch_id_reg    <= ch_id_next;
      rr_ptr_reg   <= rr_ptr_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  assign CH_ID = ch_id_reg;

endmodule
